// File: rtl/icache_sa.sv
// icache_sa: N-way set-associative instruction cache with tree-PLRU replacement, refill FSM and flush walker
module icache_sa #(
    parameter int XLEN      = 64,
    parameter int LINE_BITS = 1024,
    parameter int SETS      = 4,
    parameter int WAYS      = 4
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 req,
    input  logic [XLEN-1:0]      pc,
    output logic [31:0]          ir,
    output logic                 ir_vld,
    input  logic                 flush,
    output logic                 busy,
    output logic                 b_rd,
    output logic [XLEN-1:0]      b_addr,
    input  logic [LINE_BITS-1:0] b_data,
    input  logic                 b_dv
);
    localparam int OB = $clog2(LINE_BITS / 8);
    localparam int SB = $clog2(SETS);
    localparam int TW = XLEN - OB - SB;
    localparam int WB = $clog2(WAYS);
    localparam int PB = WAYS - 1;

    typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

    state_t               state, state_nx;
    logic [LINE_BITS-1:0] data [SETS][WAYS];
    logic [TW-1:0]        tags [SETS][WAYS];
    logic [WAYS-1:0]      valid [SETS];
    logic [PB-1:0]        plru [SETS];
    logic [SB-1:0]        set_i, set_l, fcnt;
    logic [TW-1:0]        tag_i;
    logic [WB-1:0]        hit_way, inv_way, way_l, victim;
    logic                 hit_any, inv_any, flush_pend;
    logic [LINE_BITS-1:0] line_hit;
    logic [OB+2:0]        bsel;
    logic                 unused_pc;

    // walk the PLRU tree: each node bit says which subtree holds the older way
    function automatic logic [WB-1:0] plru_victim(input logic [PB-1:0] p);
        int n;
        n = 1;
        for (int l = 0; l < WB; l++) n = 2 * n + int'(p[n-1]);
        return WB'(n - WAYS);
    endfunction

    // point every node on the path to way w towards the other subtree
    function automatic logic [PB-1:0] plru_touch(input logic [PB-1:0] p, input logic [WB-1:0] w);
        int n;
        logic [PB-1:0] r;
        r = p;
        n = 1;
        for (int l = 0; l < WB; l++) begin
            r[n-1] = ~w[WB-1-l];
            n = 2 * n + int'(w[WB-1-l]);
        end
        return r;
    endfunction

    assign set_i     = pc[OB +: SB];
    assign tag_i     = pc[XLEN-1 -: TW];
    assign bsel      = {pc[OB-1:2], 5'd0};
    assign line_hit  = data[set_i][hit_way];
    assign ir        = line_hit[bsel +: 32];
    assign victim    = inv_any ? inv_way : plru_victim(plru[set_i]);
    assign ir_vld    = state == IDLE && req && hit_any && !flush;
    assign busy      = state != IDLE;
    assign unused_pc = ^pc[1:0];

    // tag compare across the indexed set; descending scan leaves the lowest matching/invalid way
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[set_i][w] && tags[set_i][w] == tag_i) begin
                hit_any = 1'b1;
                hit_way = WB'(w);
            end
            if (!valid[set_i][w]) begin
                inv_any = 1'b1;
                inv_way = WB'(w);
            end
        end
    end

    // next state: flush beats a miss; a flush seen during refill is replayed after the fill
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = flush ? FLUSH : (req && !hit_any) ? REFILL : IDLE;
            REFILL:  state_nx = b_dv ? ((flush_pend || flush) ? FLUSH : IDLE) : REFILL;
            FLUSH:   state_nx = (fcnt == SB'(SETS - 1)) ? IDLE : FLUSH;
            default: state_nx = IDLE;
        endcase
    end

    // control registers: state, latched miss address/victim, pending flush, walk counter
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            b_rd       <= 1'b0;
            b_addr     <= '0;
            set_l      <= '0;
            way_l      <= '0;
            fcnt       <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nx;
            if (state == IDLE && state_nx == REFILL) begin
                b_rd   <= 1'b1;
                b_addr <= {pc[XLEN-1:OB], {OB{1'b0}}};
                set_l  <= set_i;
                way_l  <= victim;
            end
            if (state == REFILL && b_dv) b_rd <= 1'b0;
            flush_pend <= state == REFILL && !b_dv && (flush_pend || flush);
            fcnt       <= state == FLUSH ? fcnt + SB'(1) : '0;
        end
    end

    // valid and PLRU bits: cleared by the flush walker, set by refill, aged by hits
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            valid <= '{default: '0};
            plru  <= '{default: '0};
        end else if (state == FLUSH) begin
            valid[fcnt] <= '0;
            plru[fcnt]  <= '0;
        end else if (state == REFILL && b_dv) begin
            valid[set_l][way_l] <= 1'b1;
            plru[set_l]         <= plru_touch(plru[set_l], way_l);
        end else if (ir_vld) begin
            plru[set_i] <= plru_touch(plru[set_i], hit_way);
        end
    end

    // line data and tag storage, written only when the outstanding refill returns
    always_ff @(posedge clk) begin
        if (state == REFILL && b_dv) begin
            data[set_l][way_l] <= b_data;
            tags[set_l][way_l] <= b_addr[XLEN-1 -: TW];
        end
    end
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: table-driven directed check of icache_sa plus timing/reset corner sequences
module tb_icache_sa;
    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          req = 1'b0;
    logic [63:0]   pc = '0;
    logic [31:0]   ir;
    logic          ir_vld;
    logic          flush = 1'b0;
    logic          busy;
    logic          b_rd;
    logic [63:0]   b_addr;
    logic [1023:0] b_data = '0;
    logic          b_dv = 1'b0;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic        rst, req, fl, dv;
        logic [63:0] pc, la;
        logic        ev, erd, eb;
    } row_t;

    row_t tv[$];

    icache_sa dut (
        .clk(clk), .clr_n(clr_n), .req(req), .pc(pc), .ir(ir), .ir_vld(ir_vld),
        .flush(flush), .busy(busy), .b_rd(b_rd), .b_addr(b_addr),
        .b_data(b_data), .b_dv(b_dv)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [63:0] a);
        return ((a[31:0] - 32'h1000) << 8) | 32'h13;
    endfunction

    function automatic logic [1023:0] mk_line(input logic [63:0] base);
        logic [1023:0] l;
        for (int i = 0; i < 32; i++) l[32*i +: 32] = word(base + 64'(4 * i));
        return l;
    endfunction

    task automatic chk(input string nm, input int i, input logic [63:0] a, input logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s step %0d: got %h want %h", nm, i, a, e);
        end
    endtask

    task automatic add(input logic rst, input logic rq, input logic [63:0] p, input logic fl,
                       input logic dv, input logic [63:0] la, input logic ev, input logic erd,
                       input logic eb);
        tv.push_back('{rst: rst, req: rq, fl: fl, dv: dv, pc: p, la: la, ev: ev, erd: erd, eb: eb});
    endtask

    task automatic fill(input logic [63:0] a);
        add(0, 1, a, 0, 0, 0, 0, 0, 0);
        add(0, 1, a, 0, 1, a, 0, 1, 1);
        add(0, 1, a, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // miss on 0x1000 with a three-cycle bus, then word selection within the line
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 'h1000, 0, 0, 0, 0, 0, 0);
        add(0, 1, 'h1000, 0, 0, 'h1000, 0, 1, 1);
        add(0, 1, 'h1000, 0, 0, 'h1000, 0, 1, 1);
        add(0, 1, 'h1000, 0, 1, 'h1000, 0, 1, 1);
        add(0, 1, 'h1000, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h1004, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h107C, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h1006, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // spurious b_dv in IDLE must not install 0x2000
        add(0, 0, 0, 0, 1, 'h2000, 0, 0, 0);
        fill('h2000);
        // PLRU: four lines in set 0, re-touch ways 0 and 2, miss evicts way 1 (0x0200)
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        fill('h0000);
        fill('h0200);
        fill('h0400);
        fill('h0600);
        add(0, 1, 'h0000, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h0400, 0, 0, 0, 1, 0, 0);
        fill('h0800);
        add(0, 1, 'h0000, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h0400, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h0600, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h0200, 0, 0, 0, 0, 0, 0);
        add(0, 1, 'h0200, 0, 0, 'h0200, 0, 1, 1);
        // reset mid-refill, late b_dv ignored, then the same pc re-requests
        add(1, 1, 'h0200, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 'h0200, 0, 0, 0);
        fill('h0200);
        // flush recorded during refill, walk of SETS cycles, second flush absorbed
        add(0, 1, 'h1000, 0, 0, 0, 0, 0, 0);
        add(0, 1, 'h1000, 1, 0, 'h1000, 0, 1, 1);
        add(0, 1, 'h1000, 0, 1, 'h1000, 0, 1, 1);
        add(0, 1, 'h1000, 0, 0, 0, 0, 0, 1);
        add(0, 1, 'h1000, 1, 0, 0, 0, 0, 1);
        add(0, 1, 'h1000, 0, 0, 0, 0, 0, 1);
        add(0, 1, 'h1000, 0, 0, 0, 0, 0, 1);
        fill('h1000);
        // flush beats a simultaneous hit
        add(0, 1, 'h1000, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 'h1000, 0, 0, 0, 0, 0, 0);
        add(0, 1, 'h1000, 0, 0, 'h1000, 0, 1, 1);

        cyc;
        for (int i = 0; i < tv.size(); i++) begin
            clr_n  = !tv[i].rst;
            req    = tv[i].req;
            pc     = tv[i].pc;
            flush  = tv[i].fl;
            b_dv   = tv[i].dv;
            b_data = mk_line(tv[i].la);
            @(negedge clk);
            chk("ir_vld", i, 64'(ir_vld), 64'(tv[i].ev));
            chk("b_rd", i, 64'(b_rd), 64'(tv[i].erd));
            chk("busy", i, 64'(busy), 64'(tv[i].eb));
            if (tv[i].ev) chk("ir", i, 64'(ir), 64'(word(tv[i].pc & ~64'd3)));
            if (tv[i].erd) chk("b_addr", i, b_addr, tv[i].la);
            if (tv[i].rst) chk("b_addr_rst", i, b_addr, 64'd0);
            cyc;
        end

        // miss-to-ir_vld equals bus latency + 2 for several latencies
        for (int k = 0; k < 3; k++) begin
            int lat, n;
            lat = 1 + 2 * k;
            n = 0;
            clr_n = 1'b0; req = 1'b0; flush = 1'b0; b_dv = 1'b0;
            cyc;
            clr_n = 1'b1; req = 1'b1; pc = 64'h3000; b_data = mk_line(64'h3000);
            for (int c = 1; c <= 20 && n == 0; c++) begin
                b_dv = (c == lat + 1);
                @(negedge clk);
                if (ir_vld) n = c;
                if (ir_vld) chk("lat_ir", lat, 64'(ir), 64'(word(64'h3000)));
                cyc;
            end
            b_dv = 1'b0;
            chk("latency", lat, 64'(n), 64'(lat + 2));
        end

        // asynchronous reset in the middle of a cycle drops b_rd at once
        begin
            int w;
            w = 0;
            req = 1'b1; pc = 64'h5000;
            for (int c = 0; c < 10 && !b_rd; c++) begin
                cyc;
                w = c + 1;
            end
            chk("b_rd_wait", w, 64'(b_rd), 64'd1);
            #2 clr_n = 1'b0;
            #1;
            chk("b_rd_async", 0, 64'(b_rd), 64'd0);
            chk("busy_async", 0, 64'(busy), 64'd0);
            req = 1'b0;
            cyc;
            clr_n = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
